// File: rtl/arbitro_compuerta_if.sv
// arbitro_compuerta_if
//   Bundles the lane sensors, gate status lines and arbiter outputs shared
//   between the lane/gate environment and arbitro_compuerta.
//   master : the arbiter (drives abrir, concesion, ultimo, tiempo_agotado, falla)
//   slave  : the environment (drives solicitud, paso, abierto, cerrado,
//            bloqueo, ack)
interface arbitro_compuerta_if;
  logic [1:0] solicitud;       // level per lane: vehicle waiting/present
  logic [1:0] paso;            // one-cycle pulse per lane: vehicle passed
  logic       abierto;         // gate fully open
  logic       cerrado;         // gate fully closed
  logic       bloqueo;         // gate blocked/alarm
  logic       ack;             // operator fault acknowledge pulse
  logic       abrir;           // open request to gate FSM
  logic [1:0] concesion;       // one-hot lane grant
  logic       ultimo;          // last lane granted
  logic       tiempo_agotado;  // passage timeout pulse
  logic       falla;           // latched gate fault

  modport master (
    input  solicitud, paso, abierto, cerrado, bloqueo, ack,
    output abrir, concesion, ultimo, tiempo_agotado, falla
  );

  modport slave (
    output solicitud, paso, abierto, cerrado, bloqueo, ack,
    input  abrir, concesion, ultimo, tiempo_agotado, falla
  );
endinterface

// File: rtl/arbitro_compuerta.sv
// arbitro_compuerta
//   Shares the single parking barrier between lane 0 (entrance) and lane 1
//   (exit). Requests the gate open, grants one lane, waits for its passage,
//   releases the gate and waits for it to close. Every phase is supervised
//   by a cycle timeout; an unresponsive gate latches a fault until the
//   operator acknowledges it with the gate closed.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arbitro_compuerta_if.master (sensors in, grant/status out)
// Parameters:
//   T_ABRIR  : max cycles waiting for the gate to open
//   T_PASO   : max unblocked cycles a lane may hold the grant
//   T_CERRAR : max cycles waiting for the gate to close
//   CW       : timeout counter width (each T_* in 1..2^CW)
module arbitro_compuerta #(
  parameter int T_ABRIR  = 16,
  parameter int T_PASO   = 64,
  parameter int T_CERRAR = 16,
  parameter int CW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arbitro_compuerta_if.master   bus
);

  typedef enum logic [2:0] {
    REPOSO,
    ESPERA_ABRIR,
    CONCEDIDO,
    ESPERA_CERRAR,
    FALLA
  } estado_t;

  localparam logic [CW-1:0] LIM_ABRIR  = CW'(T_ABRIR - 1);
  localparam logic [CW-1:0] LIM_PASO   = CW'(T_PASO - 1);
  localparam logic [CW-1:0] LIM_CERRAR = CW'(T_CERRAR - 1);

  estado_t       estado;
  logic [CW-1:0] cnt;
  logic          ganador;
  logic          puede_arbitrar;

  // Winner for the next arbitration: a lone requester wins outright, a tie
  // goes to the lane that was not served last.
  always_comb begin
    ganador = 1'b0;
    case (bus.solicitud)
      2'b01:   ganador = 1'b0;
      2'b10:   ganador = 1'b1;
      2'b11:   ganador = ~bus.ultimo;
      default: ganador = 1'b0;
    endcase
  end

  assign puede_arbitrar = bus.cerrado && !bus.bloqueo && (bus.solicitud != 2'b00);

  // Single FSM with registered outputs. After arbitration, ultimo holds the
  // lane being served for the rest of the cycle, so it doubles as w.
  // cnt restarts on every state change and only holds while the granted
  // lane is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado             <= REPOSO;
      cnt                <= '0;
      bus.abrir          <= 1'b0;
      bus.concesion      <= 2'b00;
      bus.ultimo         <= 1'b1;
      bus.tiempo_agotado <= 1'b0;
      bus.falla          <= 1'b0;
    end else begin
      bus.tiempo_agotado <= 1'b0;
      cnt                <= cnt + CW'(1);

      case (estado)
        REPOSO: begin
          if (puede_arbitrar) begin
            bus.ultimo <= ganador;
            bus.abrir  <= 1'b1;
            estado     <= ESPERA_ABRIR;
            cnt        <= '0;
          end
        end

        ESPERA_ABRIR: begin
          if (bus.abierto) begin
            bus.concesion <= bus.ultimo ? 2'b10 : 2'b01;
            estado        <= CONCEDIDO;
            cnt           <= '0;
          end else if (cnt == LIM_ABRIR) begin
            bus.abrir <= 1'b0;
            bus.falla <= 1'b1;
            estado    <= FALLA;
            cnt       <= '0;
          end
        end

        CONCEDIDO: begin
          // Passage beats abandonment beats timeout; a block freezes the timer.
          if (bus.paso[bus.ultimo] || !bus.solicitud[bus.ultimo]) begin
            bus.concesion <= 2'b00;
            bus.abrir     <= 1'b0;
            estado        <= ESPERA_CERRAR;
            cnt           <= '0;
          end else if (bus.bloqueo) begin
            cnt <= cnt;
          end else if (cnt == LIM_PASO) begin
            bus.tiempo_agotado <= 1'b1;
            bus.concesion      <= 2'b00;
            bus.abrir          <= 1'b0;
            estado             <= ESPERA_CERRAR;
            cnt                <= '0;
          end
        end

        ESPERA_CERRAR: begin
          if (bus.cerrado) begin
            estado <= REPOSO;
            cnt    <= '0;
          end else if (cnt == LIM_CERRAR) begin
            bus.falla <= 1'b1;
            estado    <= FALLA;
            cnt       <= '0;
          end
        end

        FALLA: begin
          // Acknowledge is honoured only with the gate confirmed closed.
          if (bus.ack && bus.cerrado) begin
            bus.falla <= 1'b0;
            estado    <= REPOSO;
            cnt       <= '0;
          end
        end

        default: begin
          bus.abrir     <= 1'b0;
          bus.concesion <= 2'b00;
          estado        <= REPOSO;
          cnt           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// tb_arbitro_compuerta
//   Directed bench for arbitro_compuerta: single entrance, tie round robin,
//   passage timeout with and without a block, gate fault with acknowledge,
//   abandonment with ignored foreign Paso, and reset in the middle of a grant.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_arbitro_compuerta;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  arbitro_compuerta_if bus ();

  arbitro_compuerta #(
    .T_ABRIR  (16),
    .T_PASO   (64),
    .T_CERRAR (16),
    .CW       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives every environment input at once.
  task automatic applyStimulus(input logic [1:0] sol, input logic [1:0] pas,
                               input logic abi, input logic cer,
                               input logic blo, input logic ak);
    bus.solicitud = sol;
    bus.paso      = pas;
    bus.abierto   = abi;
    bus.cerrado   = cer;
    bus.bloqueo   = blo;
    bus.ack       = ak;
  endtask

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // ---------------- single entrance ----------------
    rst_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("rst_abrir",     {7'd0, bus.abrir},          8'd0);
    checkOutput("rst_concesion", {6'd0, bus.concesion},      8'd0);
    checkOutput("rst_ultimo",    {7'd0, bus.ultimo},         8'd1);
    checkOutput("rst_tiempo",    {7'd0, bus.tiempo_agotado}, 8'd0);
    checkOutput("rst_falla",     {7'd0, bus.falla},          8'd0);
    rst_n = 1'b1;
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("e1_abrir",  {7'd0, bus.abrir},     8'd1);
    checkOutput("e1_ultimo", {7'd0, bus.ultimo},    8'd0);
    checkOutput("e1_nogrant",{6'd0, bus.concesion}, 8'd0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("e1_wait_open", {6'd0, bus.concesion}, 8'd0);
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("e1_grant", {6'd0, bus.concesion}, 8'd1);
    applyStimulus(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("e1_paso_conc",  {6'd0, bus.concesion}, 8'd0);
    checkOutput("e1_paso_abrir", {7'd0, bus.abrir},     8'd0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("e1_idle_abrir", {7'd0, bus.abrir},  8'd0);
    checkOutput("e1_idle_falla", {7'd0, bus.falla},  8'd0);
    checkOutput("e1_ultimo_end", {7'd0, bus.ultimo}, 8'd0);

    // ---------------- simultaneous requests ----------------
    rst_n = 1'b0;
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("tie_first_ultimo", {7'd0, bus.ultimo}, 8'd0);
    checkOutput("tie_first_abrir",  {7'd0, bus.abrir},  8'd1);
    applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("tie_first_grant", {6'd0, bus.concesion}, 8'd1);
    applyStimulus(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("tie_first_done", {6'd0, bus.concesion}, 8'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("tie_second_ultimo", {7'd0, bus.ultimo}, 8'd1);
    checkOutput("tie_second_abrir",  {7'd0, bus.abrir},  8'd1);
    applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("tie_second_grant", {6'd0, bus.concesion}, 8'd2);

    // ---------------- passage timeout, lane 1 ----------------
    waitCycles(63);
    checkOutput("to_hold_conc",   {6'd0, bus.concesion},      8'd2);
    checkOutput("to_hold_tiempo", {7'd0, bus.tiempo_agotado}, 8'd0);
    waitCycles(1);
    checkOutput("to_pulse",       {7'd0, bus.tiempo_agotado}, 8'd1);
    checkOutput("to_conc",        {6'd0, bus.concesion},      8'd0);
    checkOutput("to_abrir",       {7'd0, bus.abrir},          8'd0);
    waitCycles(1);
    checkOutput("to_pulse_end",   {7'd0, bus.tiempo_agotado}, 8'd0);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("tob_ultimo", {7'd0, bus.ultimo}, 8'd1);
    applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("tob_grant", {6'd0, bus.concesion}, 8'd2);
    waitCycles(10);
    applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    waitCycles(20);
    checkOutput("tob_blocked_conc",  {6'd0, bus.concesion}, 8'd2);
    checkOutput("tob_blocked_abrir", {7'd0, bus.abrir},     8'd1);
    applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(53);
    checkOutput("tob_hold_tiempo", {7'd0, bus.tiempo_agotado}, 8'd0);
    checkOutput("tob_hold_conc",   {6'd0, bus.concesion},      8'd2);
    waitCycles(1);
    checkOutput("tob_pulse", {7'd0, bus.tiempo_agotado}, 8'd1);
    checkOutput("tob_conc",  {6'd0, bus.concesion},      8'd0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(2);

    // ---------------- gate fault ----------------
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("gf_abrir", {7'd0, bus.abrir}, 8'd1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(15);
    checkOutput("gf_pre_falla", {7'd0, bus.falla}, 8'd0);
    checkOutput("gf_pre_abrir", {7'd0, bus.abrir}, 8'd1);
    waitCycles(1);
    checkOutput("gf_falla",      {7'd0, bus.falla},     8'd1);
    checkOutput("gf_abrir_drop", {7'd0, bus.abrir},     8'd0);
    checkOutput("gf_conc",       {6'd0, bus.concesion}, 8'd0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("gf_ack_open", {7'd0, bus.falla}, 8'd1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("gf_ack_closed", {7'd0, bus.falla}, 8'd0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("gf_reposo_abrir",  {7'd0, bus.abrir},  8'd1);
    checkOutput("gf_reposo_ultimo", {7'd0, bus.ultimo}, 8'd0);

    // ---------------- abandonment / foreign Paso ----------------
    applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("ab_grant", {6'd0, bus.concesion}, 8'd1);
    applyStimulus(2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("ab_foreign_conc",  {6'd0, bus.concesion}, 8'd1);
    checkOutput("ab_foreign_abrir", {7'd0, bus.abrir},     8'd1);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("ab_drop_conc",  {6'd0, bus.concesion}, 8'd0);
    checkOutput("ab_drop_abrir", {7'd0, bus.abrir},     8'd0);
    checkOutput("ab_no_tiempo",  {7'd0, bus.tiempo_agotado}, 8'd0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);

    // ---------------- reset mid-grant ----------------
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("rm_grant", {6'd0, bus.concesion}, 8'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rm_async_conc",  {6'd0, bus.concesion}, 8'd0);
    checkOutput("rm_async_abrir", {7'd0, bus.abrir},     8'd0);
    checkOutput("rm_ultimo",      {7'd0, bus.ultimo},    8'd1);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("rm_tie_ultimo", {7'd0, bus.ultimo}, 8'd0);
    checkOutput("rm_tie_abrir",  {7'd0, bus.abrir},  8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
